// File: rtl/cycle_counter_if.sv
// Control/status bundle between the writeback stage and the cycle counter.
// Carries divide value, halt/sleep requests, wake lines and counter status.
interface cycle_counter_if #(
    parameter int CNT_WIDTH = 32
);
    logic [CNT_WIDTH-1:0] clock_divider;
    logic                 wb_halt;
    logic                 wb_sleep;
    logic [15:0]          interrupts;
    logic                 clk_en;
    logic                 halted;
    logic                 sleeping;
    logic                 halt_or_sleep;
    logic [CNT_WIDTH-1:0] count;

    modport master (
        output clock_divider,
        output wb_halt,
        output wb_sleep,
        output interrupts,
        input  clk_en,
        input  halted,
        input  sleeping,
        input  halt_or_sleep,
        input  count
    );

    modport slave (
        input  clock_divider,
        input  wb_halt,
        input  wb_sleep,
        input  interrupts,
        output clk_en,
        output halted,
        output sleeping,
        output halt_or_sleep,
        output count
    );
endinterface

// File: rtl/cycle_counter.sv
// Free-running cycle counter with pipeline clock-enable divider and
// sticky halt / interrupt-woken sleep state.
module cycle_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    cycle_counter_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] div_cnt;
    logic                 clk_en_q;
    logic                 halted_q;
    logic                 sleeping_q;

    logic [CNT_WIDTH-1:0] count_d;
    logic [CNT_WIDTH-1:0] div_cnt_d;
    logic                 clk_en_d;
    logic                 halted_d;
    logic                 sleeping_d;

    always_comb begin
        count_d    = count_q;
        div_cnt_d  = div_cnt + ONE;
        clk_en_d   = 1'b0;
        halted_d   = halted_q;
        sleeping_d = sleeping_q;

        if (!halted_q)
            count_d = count_q + ONE;

        // >= rather than == so a shrinking divide value cannot strand div_cnt
        if (div_cnt >= bus.clock_divider) begin
            div_cnt_d = '0;
            clk_en_d  = 1'b1;
        end

        if (clk_en_q) begin
            halted_d = halted_q | bus.wb_halt;
            if (sleeping_q)
                sleeping_d = (bus.interrupts == 16'h0000);
            else
                sleeping_d = bus.wb_sleep;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            div_cnt    <= '0;
            clk_en_q   <= 1'b1;
            halted_q   <= 1'b0;
            sleeping_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            div_cnt    <= div_cnt_d;
            clk_en_q   <= clk_en_d;
            halted_q   <= halted_d;
            sleeping_q <= sleeping_d;
        end
    end

    assign bus.count         = count_q;
    assign bus.clk_en        = clk_en_q;
    assign bus.halted        = halted_q;
    assign bus.sleeping      = sleeping_q;
    assign bus.halt_or_sleep = halted_q | sleeping_q;
endmodule

// File: tb/tb_cycle_counter.sv
// Directed bench for cycle_counter: vector table for the divide-by-4
// halt/sleep walk, hand sequences for reset, wrap and divider changes.
module tb_cycle_counter;
    logic clk;
    logic rst_n;

    cycle_counter_if #(.CNT_WIDTH(32)) bus ();
    cycle_counter_if #(.CNT_WIDTH(4))  sbus ();

    cycle_counter #(.CNT_WIDTH(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    cycle_counter #(.CNT_WIDTH(4)) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wb_halt;
        logic        wb_sleep;
        logic [15:0] irq;
        logic        en;
        logic        halted;
        logic        sleeping;
        logic [31:0] count;
    } vec_t;

    vec_t vecs[22];
    int   total;
    int   bad;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic h, input logic s,
                           input logic [15:0] irq);
        bus.wb_halt    = h;
        bus.wb_sleep   = s;
        bus.interrupts = irq;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic fill(input int i, input logic h, input logic s,
                        input logic [15:0] irq, input logic en,
                        input logic hl, input logic sl,
                        input logic [31:0] c);
        vecs[i].wb_halt  = h;
        vecs[i].wb_sleep = s;
        vecs[i].irq      = irq;
        vecs[i].en       = en;
        vecs[i].halted   = hl;
        vecs[i].sleeping = sl;
        vecs[i].count    = c;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // divide-by-4 walk: halt ignored off-enable, sleep/wake, then halt
        fill(0,  0, 0, 16'h0000, 0, 0, 0, 1);
        fill(1,  1, 0, 16'h0000, 0, 0, 0, 2);
        fill(2,  0, 0, 16'h0000, 0, 0, 0, 3);
        fill(3,  0, 0, 16'h0000, 1, 0, 0, 4);
        fill(4,  0, 1, 16'h0000, 0, 0, 1, 5);
        fill(5,  0, 0, 16'h0000, 0, 0, 1, 6);
        fill(6,  0, 0, 16'h8000, 0, 0, 1, 7);
        fill(7,  0, 0, 16'h0000, 1, 0, 1, 8);
        fill(8,  0, 0, 16'h0000, 0, 0, 1, 9);
        fill(9,  0, 0, 16'h0000, 0, 0, 1, 10);
        fill(10, 0, 0, 16'h0000, 0, 0, 1, 11);
        fill(11, 0, 0, 16'h0000, 1, 0, 1, 12);
        fill(12, 0, 0, 16'h8000, 0, 0, 0, 13);
        fill(13, 1, 0, 16'h0000, 0, 0, 0, 14);
        fill(14, 1, 0, 16'h0000, 0, 0, 0, 15);
        fill(15, 1, 0, 16'h0000, 1, 0, 0, 16);
        fill(16, 1, 0, 16'h0000, 0, 1, 0, 17);
        fill(17, 0, 0, 16'h0000, 0, 1, 0, 17);
        fill(18, 0, 0, 16'h0000, 0, 1, 0, 17);
        fill(19, 0, 0, 16'h0000, 1, 1, 0, 17);
        fill(20, 0, 1, 16'h0000, 0, 1, 1, 17);
        fill(21, 0, 0, 16'h0000, 0, 1, 1, 17);

        rst_n              = 1'b0;
        bus.clock_divider  = 32'd0;
        sbus.clock_divider = 4'd0;
        sbus.wb_halt       = 1'b0;
        sbus.wb_sleep      = 1'b0;
        sbus.interrupts    = 16'h0000;
        set_req(0, 0, 16'h0000);
        #12;

        chk("rst_count",    bus.count, 0);
        chk("rst_clk_en",   {31'd0, bus.clk_en}, 1);
        chk("rst_halted",   {31'd0, bus.halted}, 0);
        chk("rst_sleeping", {31'd0, bus.sleeping}, 0);
        chk("rst_hos",      {31'd0, bus.halt_or_sleep}, 0);
        rst_n = 1'b1;

        // divide-by-1, plus 4-bit instance wrapping 15 -> 0
        for (int i = 1; i <= 17; i++) begin
            logic [31:0] wrapped;
            wrapped = 32'(i % 16);
            tick();
            chk("div0_clk_en", {31'd0, bus.clk_en}, 1);
            chk("div0_count", bus.count, 32'(i));
            chk("small_count", {28'd0, sbus.count}, wrapped);
        end

        bus.clock_divider = 32'd3;
        pulse_reset();
        for (int i = 0; i < 22; i++) begin
            set_req(vecs[i].wb_halt, vecs[i].wb_sleep, vecs[i].irq);
            tick();
            chk($sformatf("vec%0d_clk_en", i), {31'd0, bus.clk_en},
                {31'd0, vecs[i].en});
            chk($sformatf("vec%0d_halted", i), {31'd0, bus.halted},
                {31'd0, vecs[i].halted});
            chk($sformatf("vec%0d_sleeping", i), {31'd0, bus.sleeping},
                {31'd0, vecs[i].sleeping});
            chk($sformatf("vec%0d_hos", i), {31'd0, bus.halt_or_sleep},
                {31'd0, vecs[i].halted | vecs[i].sleeping});
            chk($sformatf("vec%0d_count", i), bus.count, vecs[i].count);
        end

        // async reset between edges clears sticky halt at once
        set_req(0, 0, 16'h0000);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_halted",   {31'd0, bus.halted}, 0);
        chk("mid_rst_sleeping", {31'd0, bus.sleeping}, 0);
        chk("mid_rst_count",    bus.count, 0);
        chk("mid_rst_clk_en",   {31'd0, bus.clk_en}, 1);
        #1;
        rst_n = 1'b1;
        bus.clock_divider = 32'd0;
        tick();
        chk("resume_count",  bus.count, 1);
        chk("resume_halted", {31'd0, bus.halted}, 0);

        // simultaneous halt and sleep
        set_req(1, 1, 16'h0000);
        tick();
        chk("both_halted",   {31'd0, bus.halted}, 1);
        chk("both_sleeping", {31'd0, bus.sleeping}, 1);
        chk("both_count",    bus.count, 2);
        set_req(0, 0, 16'h0000);
        tick();
        chk("both_frozen",   bus.count, 2);
        chk("both_hos",      {31'd0, bus.halt_or_sleep}, 1);

        // shrinking divide value below div_cnt forces an enable
        bus.clock_divider = 32'd3;
        pulse_reset();
        tick();
        tick();
        chk("shrink_pre_en", {31'd0, bus.clk_en}, 0);
        bus.clock_divider = 32'd1;
        tick();
        chk("shrink_en",     {31'd0, bus.clk_en}, 1);
        tick();
        chk("shrink_en_lo",  {31'd0, bus.clk_en}, 0);
        tick();
        chk("shrink_en_hi",  {31'd0, bus.clk_en}, 1);
        chk("shrink_count",  bus.count, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
